mem_wb_stage_lsu: RTL and testbench

- Parametrised memory stage of the 5-stage RISC-V pipeline, between EX/MEM and writeback.
- Adds byte/halfword load-store with sign/zero extension, misalignment detection, and stall/flush control of the MEM/WB register.
- Contains its own byte-enabled data memory and the MEM/WB pipeline register.

---
 rtl/mem_wb_stage_lsu.sv | 84 ++++++++
 tb/tb_mem_wb_stage_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_lsu.sv
// mem_wb_stage_lsu: RISC-V MEM stage with byte-enabled data memory, load extension and MEM/WB register
module mem_wb_stage_lsu #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallM,
    input  logic            FlushM,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic            MemReadM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] PCPlus4M,
    output logic            FaultM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALUResultW,
    output logic            FaultW
);
    logic [31:0] mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] idx;
    logic [1:0] lane;
    logic [31:0] word, wdata, loadData, readData;
    logic [15:0] rHalf;
    logic [7:0] rByte;
    logic [3:0] be;
    logic illegal, misaligned, memWe;

    assign idx        = ALUResultM[ADDR_W+1:2];
    assign lane       = ALUResultM[1:0];
    assign illegal    = (Funct3M == 3'b011) | (Funct3M[2] & Funct3M[1]) | (Funct3M[2] & MemWriteM);
    assign misaligned = ((Funct3M[1:0] == 2'b01) & lane[0]) | ((Funct3M[1:0] == 2'b10) & (lane != 2'b00));
    assign FaultM     = (MemReadM | MemWriteM) & (illegal | misaligned);
    // rst in the enable keeps a store from landing while reset is held
    assign memWe      = MemWriteM & ~FaultM & ~StallM & ~FlushM & rst;

    always_comb begin
        be       = Funct3M[1:0] == 2'b00 ? 4'b0001 << lane :
                   Funct3M[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata    = Funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} :
                   Funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
        word     = mem[idx];
        rByte    = word[{lane, 3'b000} +: 8];
        rHalf    = lane[1] ? word[31:16] : word[15:0];
        loadData = Funct3M == 3'b000 ? {{24{rByte[7]}}, rByte} :
                   Funct3M == 3'b001 ? {{16{rHalf[15]}}, rHalf} :
                   Funct3M == 3'b010 ? word :
                   Funct3M == 3'b100 ? {24'd0, rByte} :
                   Funct3M == 3'b101 ? {16'd0, rHalf} : 32'd0;
        readData = (MemReadM & ~FaultM) ? loadData : 32'd0;
    end

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (memWe & be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];

    always_ff @(posedge clk or negedge rst)
        if (!rst || FlushM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            ALUResultW <= '0;
            FaultW     <= 1'b0;
        end else if (!StallM) begin
            RegWriteW  <= RegWriteM & ~(MemReadM & FaultM);
            ResultSrcW <= ResultSrcM;
            ReadDataW  <= readData;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            ALUResultW <= ALUResultM;
            FaultW     <= FaultM;
        end
endmodule

// File: tb/tb_mem_wb_stage_lsu.sv
// tb_mem_wb_stage_lsu: directed scenario tests for mem_wb_stage_lsu
module tb_mem_wb_stage_lsu;
    logic clk = 1'b0, rst = 1'b0;
    logic StallM, FlushM, RegWriteM, MemWriteM, MemReadM;
    logic [1:0] ResultSrcM;
    logic [2:0] Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0] RdM;
    logic FaultM, RegWriteW, FaultW;
    logic [1:0] ResultSrcW;
    logic [31:0] ReadDataW, PCPlus4W, ALUResultW;
    logic [4:0] RdW;
    int checks = 0, failures = 0;

    mem_wb_stage_lsu dut (
        .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .FaultM(FaultM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
        .RdW(RdW), .PCPlus4W(PCPlus4W), .ALUResultW(ALUResultW), .FaultW(FaultW)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic mw, input logic mr, input logic rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        StallM = 1'b0; FlushM = 1'b0;
        MemWriteM = mw; MemReadM = mr; RegWriteM = rw; Funct3M = f3;
        ALUResultM = a; WriteDataM = wd; RdM = rd;
        ResultSrcM = mr ? 2'b01 : 2'b00;
        PCPlus4M = a + 32'd4;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        drv(1'b1, 1'b0, 1'b0, f3, a, wd, 5'd0);
        step();
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
        drv(1'b0, 1'b1, 1'b1, f3, a, 32'd0, rd);
        step();
    endtask

    task automatic test_reset();
        drv(1'b1, 1'b1, 1'b1, 3'b010, 32'h44, 32'h1234_5678, 5'd3);
        step(); step();
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", RegWriteW); end
        checks++; if (ResultSrcW !== 2'b00) begin failures++; $display("FAIL reset_resultsrc got=%b exp=00", ResultSrcW); end
        checks++; if (ReadDataW !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", ReadDataW); end
        checks++; if (RdW !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", RdW); end
        checks++; if (PCPlus4W !== 32'd0) begin failures++; $display("FAIL reset_pcplus4 got=%h exp=0", PCPlus4W); end
        checks++; if (ALUResultW !== 32'd0) begin failures++; $display("FAIL reset_alu got=%h exp=0", ALUResultW); end
        checks++; if (FaultW !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", FaultW); end
        drv(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        rst = 1'b1;
        step();
    endtask

    task automatic test_sw_lw();
        store(3'b010, 32'h10, 32'hDEAD_BEEF);
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL sw_regwrite got=%b exp=0", RegWriteW); end
        checks++; if (ReadDataW !== 32'd0) begin failures++; $display("FAIL sw_readdata got=%h exp=0", ReadDataW); end
        load(3'b010, 32'h10, 5'd5);
        checks++; if (ReadDataW !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", ReadDataW); end
        checks++; if (RegWriteW !== 1'b1) begin failures++; $display("FAIL lw_regwrite got=%b exp=1", RegWriteW); end
        checks++; if (FaultW !== 1'b0) begin failures++; $display("FAIL lw_fault got=%b exp=0", FaultW); end
        checks++; if (RdW !== 5'd5) begin failures++; $display("FAIL lw_rd got=%0d exp=5", RdW); end
        checks++; if (PCPlus4W !== 32'h14) begin failures++; $display("FAIL lw_pcplus4 got=%h exp=14", PCPlus4W); end
        checks++; if (ResultSrcW !== 2'b01) begin failures++; $display("FAIL lw_resultsrc got=%b exp=01", ResultSrcW); end
        checks++; if (ALUResultW !== 32'h10) begin failures++; $display("FAIL lw_alu got=%h exp=10", ALUResultW); end
    endtask

    task automatic test_extension();
        logic [2:0] f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100};
        logic [31:0] a [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11};
        logic [31:0] e [6] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF, 32'hFFFF_FFEF, 32'h0000_00BE};
        for (int i = 0; i < 6; i++) begin
            load(f3[i], a[i], 5'd1);
            checks++; if (ReadDataW !== e[i]) begin failures++; $display("FAIL ext_%0d got=%h exp=%h", i, ReadDataW, e[i]); end
        end
    endtask

    task automatic test_sub_store();
        store(3'b000, 32'h11, 32'h1234_5677);
        load(3'b010, 32'h10, 5'd2);
        checks++; if (ReadDataW !== 32'hDEAD_77EF) begin failures++; $display("FAIL sb_merge got=%h exp=dead77ef", ReadDataW); end
        store(3'b001, 32'h12, 32'h0000_CAFE);
        load(3'b010, 32'h10, 5'd2);
        checks++; if (ReadDataW !== 32'hCAFE_77EF) begin failures++; $display("FAIL sh_merge got=%h exp=cafe77ef", ReadDataW); end
    endtask

    task automatic test_fault();
        drv(1'b0, 1'b1, 1'b1, 3'b010, 32'h12, 32'd0, 5'd4);
        #1;
        checks++; if (FaultM !== 1'b1) begin failures++; $display("FAIL lw_mis_faultm got=%b exp=1", FaultM); end
        step();
        checks++; if (FaultW !== 1'b1) begin failures++; $display("FAIL lw_mis_faultw got=%b exp=1", FaultW); end
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL lw_mis_regwrite got=%b exp=0", RegWriteW); end
        checks++; if (ReadDataW !== 32'd0) begin failures++; $display("FAIL lw_mis_data got=%h exp=0", ReadDataW); end
        drv(1'b1, 1'b0, 1'b0, 3'b001, 32'h13, 32'h0000_1111, 5'd0);
        #1;
        checks++; if (FaultM !== 1'b1) begin failures++; $display("FAIL sh_mis_faultm got=%b exp=1", FaultM); end
        step();
        drv(1'b0, 1'b1, 1'b1, 3'b011, 32'h10, 32'd0, 5'd4);
        #1;
        checks++; if (FaultM !== 1'b1) begin failures++; $display("FAIL f3_011_faultm got=%b exp=1", FaultM); end
        drv(1'b1, 1'b0, 1'b0, 3'b100, 32'h10, 32'hFFFF_FFFF, 5'd0);
        #1;
        checks++; if (FaultM !== 1'b1) begin failures++; $display("FAIL sbu_faultm got=%b exp=1", FaultM); end
        step();
        drv(1'b0, 1'b0, 1'b1, 3'b010, 32'h12, 32'd0, 5'd4);
        #1;
        checks++; if (FaultM !== 1'b0) begin failures++; $display("FAIL noaccess_faultm got=%b exp=0", FaultM); end
        load(3'b010, 32'h10, 5'd4);
        checks++; if (ReadDataW !== 32'hCAFE_77EF) begin failures++; $display("FAIL fault_nowrite got=%h exp=cafe77ef", ReadDataW); end
    endtask

    task automatic test_stall();
        store(3'b010, 32'h20, 32'd0);
        store(3'b010, 32'h28, 32'h1111_2222);
        load(3'b010, 32'h10, 5'd7);
        drv(1'b1, 1'b0, 1'b0, 3'b010, 32'h20, 32'hA5A5_A5A5, 5'd9);
        StallM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (ReadDataW !== 32'hCAFE_77EF) begin failures++; $display("FAIL stall_data_%0d got=%h exp=cafe77ef", i, ReadDataW); end
            checks++; if (RdW !== 5'd7) begin failures++; $display("FAIL stall_rd_%0d got=%0d exp=7", i, RdW); end
            checks++; if (RegWriteW !== 1'b1) begin failures++; $display("FAIL stall_regwrite_%0d got=%b exp=1", i, RegWriteW); end
            checks++; if (ALUResultW !== 32'h10) begin failures++; $display("FAIL stall_alu_%0d got=%h exp=10", i, ALUResultW); end
        end
        StallM = 1'b0;
        step();
        checks++; if (RdW !== 5'd9) begin failures++; $display("FAIL stall_release_rd got=%0d exp=9", RdW); end
        load(3'b010, 32'h20, 5'd1);
        checks++; if (ReadDataW !== 32'hA5A5_A5A5) begin failures++; $display("FAIL stall_write got=%h exp=a5a5a5a5", ReadDataW); end
        drv(1'b1, 1'b0, 1'b0, 3'b010, 32'h28, 32'hDEAD_0000, 5'd0);
        StallM = 1'b1;
        step();
        StallM = 1'b0; FlushM = 1'b1;
        step();
        load(3'b010, 32'h28, 5'd1);
        checks++; if (ReadDataW !== 32'h1111_2222) begin failures++; $display("FAIL stall_nowrite got=%h exp=11112222", ReadDataW); end
    endtask

    task automatic test_flush();
        store(3'b010, 32'h24, 32'h0BAD_F00D);
        load(3'b010, 32'h10, 5'd6);
        drv(1'b1, 1'b0, 1'b1, 3'b010, 32'h24, 32'h5555_5555, 5'd8);
        FlushM = 1'b1;
        step();
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL flush_regwrite got=%b exp=0", RegWriteW); end
        checks++; if (RdW !== 5'd0) begin failures++; $display("FAIL flush_rd got=%0d exp=0", RdW); end
        checks++; if (ALUResultW !== 32'd0) begin failures++; $display("FAIL flush_alu got=%h exp=0", ALUResultW); end
        checks++; if (PCPlus4W !== 32'd0) begin failures++; $display("FAIL flush_pcplus4 got=%h exp=0", PCPlus4W); end
        load(3'b010, 32'h24, 5'd6);
        checks++; if (ReadDataW !== 32'h0BAD_F00D) begin failures++; $display("FAIL flush_nowrite got=%h exp=0badf00d", ReadDataW); end
        drv(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'd0, 5'd6);
        FlushM = 1'b1; StallM = 1'b1;
        step();
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL flushstall_regwrite got=%b exp=0", RegWriteW); end
        checks++; if (RdW !== 5'd0) begin failures++; $display("FAIL flushstall_rd got=%0d exp=0", RdW); end
        checks++; if (ReadDataW !== 32'd0) begin failures++; $display("FAIL flushstall_data got=%h exp=0", ReadDataW); end
    endtask

    task automatic test_reset_mid();
        store(3'b010, 32'h30, 32'h1357_2468);
        load(3'b010, 32'h10, 5'd11);
        drv(1'b1, 1'b0, 1'b1, 3'b010, 32'h30, 32'hFFFF_FFFF, 5'd12);
        #1 rst = 1'b0;
        #1;
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL midrst_regwrite got=%b exp=0", RegWriteW); end
        checks++; if (ReadDataW !== 32'd0) begin failures++; $display("FAIL midrst_data got=%h exp=0", ReadDataW); end
        checks++; if (RdW !== 5'd0) begin failures++; $display("FAIL midrst_rd got=%0d exp=0", RdW); end
        step();
        checks++; if (ALUResultW !== 32'd0) begin failures++; $display("FAIL midrst_hold_alu got=%h exp=0", ALUResultW); end
        drv(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        rst = 1'b1;
        load(3'b010, 32'h30, 5'd13);
        checks++; if (ReadDataW !== 32'h1357_2468) begin failures++; $display("FAIL midrst_nowrite got=%h exp=13572468", ReadDataW); end
    endtask

    task automatic test_alias();
        store(3'b010, 32'h0000_1008, 32'h600D_CAFE);
        load(3'b010, 32'h8, 5'd14);
        checks++; if (ReadDataW !== 32'h600D_CAFE) begin failures++; $display("FAIL alias_data got=%h exp=600dcafe", ReadDataW); end
        checks++; if (ALUResultW !== 32'h8) begin failures++; $display("FAIL alias_alu got=%h exp=8", ALUResultW); end
    endtask

    task automatic test_back_to_back();
        store(3'b010, 32'h40, 32'h0102_0304);
        store(3'b010, 32'h44, 32'h0A0B_0C0D);
        load(3'b010, 32'h40, 5'd15);
        checks++; if (ReadDataW !== 32'h0102_0304) begin failures++; $display("FAIL b2b_0 got=%h exp=01020304", ReadDataW); end
        load(3'b001, 32'h46, 5'd16);
        checks++; if (ReadDataW !== 32'h0000_0A0B) begin failures++; $display("FAIL b2b_1 got=%h exp=00000a0b", ReadDataW); end
        load(3'b000, 32'h41, 5'd17);
        checks++; if (ReadDataW !== 32'h0000_0003) begin failures++; $display("FAIL b2b_2 got=%h exp=00000003", ReadDataW); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_extension();
        test_sub_store();
        test_fault();
        test_stall();
        test_flush();
        test_reset_mid();
        test_alias();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
